alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq_pkg.sv | 24 ++
 rtl/alu_seq_comb.sv | 33 +++
 rtl/alu_seq.sv | 166 ++++++++++++++++
 tb/tb_alu_seq.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and default widths for the sequential ALU.
package alu_seq_pkg;

    localparam int DEF_W   = 8;
    localparam int DEF_OPW = 3;

    typedef enum logic [DEF_OPW-1:0] {
        OP_ADD = 3'b000,
        OP_SHR = 3'b001,
        OP_SHL = 3'b010,
        OP_XOR = 3'b011,
        OP_SUB = 3'b100,
        OP_AND = 3'b101,
        OP_OR  = 3'b110,
        OP_MUL = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

endpackage

// File: rtl/alu_seq_comb.sv
// Single-cycle ALU ops (ADD/SUB/XOR/AND/OR) with carry / no-borrow output.
module alu_seq_comb
    import alu_seq_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  op_t          op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] result,
    output logic         carry
);

    logic [W:0] sum;

    always_comb begin
        sum    = {1'b0, a} + {1'b0, b};
        result = '0;
        carry  = 1'b0;
        case (op)
            OP_ADD: {carry, result} = sum;
            OP_SUB: begin
                result = a - b;
                carry  = (a >= b);
            end
            OP_XOR:  result = a ^ b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: IDLE/BUSY/DONE handshake FSM with bit-serial shifts and,
// when ALU_SEQ_MUL_EN is defined, a W-cycle shift-add multiplier.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int W   = DEF_W,
    parameter int OPW = DEF_OPW
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [OPW-1:0] op,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   result,
    output logic           zero,
    output logic           sign,
    output logic           carry,
    output logic           illegal
);

    localparam int BW = W + 1;
    localparam logic [BW-1:0] W_LIMIT = BW'(W);

    state_t       state, next_state;
    op_t          op_in, op_q;
    logic [W-1:0] work, work_next, b_q;
    logic         accept, is_shift, is_mul, shift_direct, start_busy, busy_last;
    logic [W-1:0] comb_result;
    logic         comb_carry;
    logic         load, load_carry, load_illegal;
    logic [W-1:0] load_value;

`ifdef ALU_SEQ_MUL_EN
    localparam int CW = $clog2(W + 1);
    logic [W-1:0]  acc, acc_next, mplier;
    logic [CW-1:0] mul_count;
`endif

    assign op_in = op_t'(op);

    alu_seq_comb #(.W(W)) u_comb (
        .op     (op_in),
        .a      (a),
        .b      (b),
        .result (comb_result),
        .carry  (comb_carry)
    );

    always_comb begin
        accept       = in_valid && (state == IDLE);
        is_shift     = (op_in == OP_SHR) || (op_in == OP_SHL);
        shift_direct = (b == '0) || ({1'b0, b} >= W_LIMIT);
`ifdef ALU_SEQ_MUL_EN
        is_mul       = (op_in == OP_MUL);
`else
        is_mul       = 1'b0;
`endif
        start_busy   = (is_shift && !shift_direct) || is_mul;
    end

    // Shifts reuse b_q as their remaining-bit counter; MUL has its own.
    assign work_next = (op_q == OP_SHR) ? (work >> 1) : (work << 1);
`ifdef ALU_SEQ_MUL_EN
    assign acc_next  = acc + (mplier[0] ? work : '0);
    assign busy_last = (op_q == OP_MUL) ? (mul_count == CW'(1)) : (b_q == W'(1));
`else
    assign busy_last = (b_q == W'(1));
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept)    next_state = start_busy ? BUSY : DONE;
            BUSY:    if (busy_last) next_state = DONE;
            DONE:    if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_comb begin
        load         = 1'b0;
        load_value   = '0;
        load_carry   = 1'b0;
        load_illegal = 1'b0;
        if (accept && !start_busy) begin
            load = 1'b1;
            if (is_shift) begin
                load_value = (b == '0) ? a : '0;
            end else if (op_in == OP_MUL) begin
                load_illegal = 1'b1;
            end else begin
                load_value = comb_result;
                load_carry = comb_carry;
            end
        end else if ((state == BUSY) && busy_last) begin
            load = 1'b1;
`ifdef ALU_SEQ_MUL_EN
            load_value = (op_q == OP_MUL) ? acc_next : work_next;
`else
            load_value = work_next;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q    <= OP_ADD;
            work    <= '0;
            b_q     <= '0;
            result  <= '0;
            zero    <= 1'b0;
            sign    <= 1'b0;
            carry   <= 1'b0;
            illegal <= 1'b0;
        end else begin
            if (accept) begin
                op_q <= op_in;
                work <= a;
                b_q  <= b;
            end else if (state == BUSY) begin
                work <= work_next;
                b_q  <= b_q - W'(1);
            end
            if (load) begin
                result  <= load_value;
                zero    <= (load_value == '0);
                sign    <= load_value[W-1];
                carry   <= load_carry;
                illegal <= load_illegal;
            end
        end
    end

`ifdef ALU_SEQ_MUL_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc       <= '0;
            mplier    <= '0;
            mul_count <= '0;
        end else if (accept) begin
            acc       <= '0;
            mplier    <= b;
            mul_count <= CW'(W);
        end else if (state == BUSY) begin
            acc       <= acc_next;
            mplier    <= mplier >> 1;
            mul_count <= mul_count - CW'(1);
        end
    end
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed corner cases plus random ops
// against an arithmetic reference model.
module tb_alu_seq;

    localparam int W   = 8;
    localparam int OPW = 3;

    logic           clk = 1'b0;
    logic           reset;
    logic           in_valid;
    logic           in_ready;
    logic [OPW-1:0] op;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   result;
    logic           zero;
    logic           sign;
    logic           carry;
    logic           illegal;

    int checks = 0;
    int errors = 0;

    alu_seq #(.W(W), .OPW(OPW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .sign      (sign),
        .carry     (carry),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference behaviour from the opcode table using plain integer arithmetic.
    function automatic void model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                                  output logic [7:0] r, output logic c, output logic ill,
                                  output int lat);
        int ux = int'(x);
        int uy = int'(y);
        r   = 8'h00;
        c   = 1'b0;
        ill = 1'b0;
        lat = 1;
        case (o)
            3'd0: begin
                r = 8'((ux + uy) % 256);
                c = (ux + uy) > 255;
            end
            3'd1, 3'd2: begin
                if (uy >= W) r = 8'h00;
                else if (o == 3'd1) r = 8'(ux / (1 << uy));
                else r = 8'((ux * (1 << uy)) % 256);
                lat = (uy == 0 || uy >= W) ? 1 : uy + 1;
            end
            3'd3: r = x ^ y;
            3'd4: begin
                r = 8'((ux - uy + 256) % 256);
                c = ux >= uy;
            end
            3'd5: r = x & y;
            3'd6: r = x | y;
            default: begin
`ifdef ALU_SEQ_MUL_EN
                r   = 8'((ux * uy) % 256);
                lat = W + 1;
`else
                ill = 1'b1;
`endif
            end
        endcase
    endfunction

    task automatic applyStimulus(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                                 input int hold);
        logic [7:0] er;
        logic       ec;
        logic       ei;
        int         el;
        int         lat;
        model(o, x, y, er, ec, ei, el);
        @(negedge clk);
        checkOutput("idle_ready", 32'(in_ready), 32'(1));
        op = o; a = x; b = y; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        op = 3'($urandom); a = 8'($urandom); b = 8'($urandom);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("latency", 32'(lat), 32'(el));
        checkOutput("result",  32'(result), 32'(er));
        checkOutput("zero",    32'(zero), 32'(er == 8'h00));
        checkOutput("sign",    32'(sign), 32'(er[7]));
        checkOutput("carry",   32'(carry), 32'(ec));
        checkOutput("illegal", 32'(illegal), 32'(ei));
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            op = 3'($urandom); a = 8'($urandom); b = 8'($urandom);
            @(negedge clk);
            checkOutput("hold_result", 32'(result), 32'(er));
            checkOutput("hold_ready",  32'(in_ready), 32'(0));
            checkOutput("hold_valid",  32'(out_valid), 32'(1));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("release_valid", 32'(out_valid), 32'(0));
        checkOutput("release_ready", 32'(in_ready), 32'(1));
    endtask

    initial begin
        logic [2:0] ro;
        logic [7:0] rx;
        logic [7:0] ry;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op = '0; a = '0; b = '0;
        @(negedge clk);
        checkOutput("rst_ready",   32'(in_ready), 32'(1));
        checkOutput("rst_valid",   32'(out_valid), 32'(0));
        checkOutput("rst_result",  32'(result), 32'(0));
        checkOutput("rst_zero",    32'(zero), 32'(0));
        checkOutput("rst_carry",   32'(carry), 32'(0));
        checkOutput("rst_illegal", 32'(illegal), 32'(0));
        reset = 1'b0;

        $display("[TB] directed cases");
        applyStimulus(3'd0, 8'hF0, 8'h20, 0);
        applyStimulus(3'd4, 8'h05, 8'h05, 0);
        applyStimulus(3'd4, 8'h03, 8'h05, 0);
        applyStimulus(3'd2, 8'h81, 8'd3, 0);
        applyStimulus(3'd1, 8'h81, 8'd9, 0);
        applyStimulus(3'd2, 8'h81, 8'd0, 0);
        applyStimulus(3'd1, 8'h80, 8'd7, 0);
        applyStimulus(3'd7, 8'd13, 8'd11, 0);
        applyStimulus(3'd0, 8'h7F, 8'h01, 5);

        $display("[TB] random cases");
        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom);
            rx = 8'($urandom);
            ry = (ro == 3'd1 || ro == 3'd2) ? 8'($urandom_range(0, 10)) : 8'($urandom);
            applyStimulus(ro, rx, ry, (i % 8 == 0) ? 2 : 0);
        end

        $display("[TB] reset during shift");
        applyStimulus(3'd6, 8'h5A, 8'h81, 0);
        @(negedge clk);
        op = 3'd2; a = 8'h81; b = 8'd6; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checkOutput("abort_valid",   32'(out_valid), 32'(0));
        checkOutput("abort_ready",   32'(in_ready), 32'(1));
        checkOutput("abort_result",  32'(result), 32'(0));
        checkOutput("abort_zero",    32'(zero), 32'(0));
        checkOutput("abort_sign",    32'(sign), 32'(0));
        checkOutput("abort_carry",   32'(carry), 32'(0));
        checkOutput("abort_illegal", 32'(illegal), 32'(0));
        @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        checkOutput("abort_no_result", 32'(out_valid), 32'(0));
        checkOutput("abort_idle",      32'(in_ready), 32'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
